// File: rtl/tpu_gemm_engine.sv
// tpu_gemm_engine: output-stationary SxS systolic GEMM with tile sequencer.
// Define TPU_SAT_EN for saturating accumulation (default build wraps).
module tpu_gemm_engine #(
  parameter int ARRAY_SIZE = 4,
  parameter int DIM_W      = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DIM_W-1:0]             row_a,
  input  logic [DIM_W-1:0]             k,
  input  logic [DIM_W-1:0]             col_b,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_W-1:0]            index_a,
  input  logic [ARRAY_SIZE*DATA_W-1:0] rd_data_a,
  output logic [ADDR_W-1:0]            index_b,
  input  logic [ARRAY_SIZE*DATA_W-1:0] rd_data_b,
  output logic                         wr_en_out,
  output logic [ADDR_W-1:0]            index_out,
  output logic [ARRAY_SIZE*ACC_W-1:0]  wr_data_out
);
  localparam int S  = ARRAY_SIZE;
  localparam int RW = $clog2(S);
  localparam int CW = DIM_W + RW + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, FLUSH, WRITE, DONE
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DIM_W-1:0] m_q, k_q, n_q;
  logic [DIM_W-1:0] t_q, c_q, nrt, nct;
  logic last_tile, valid_q, clr;
  logic [RW-1:0] rsel;

  assign nrt = DIM_W'((int'(m_q) + S - 1) / S);
  assign nct = DIM_W'((int'(n_q) + S - 1) / S);
  assign last_tile = (t_q == nrt - 1'b1) &&
                     (c_q == nct - 1'b1);
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign clr  = (state_nxt == LOAD) && (state != LOAD);
  assign rsel = cnt[RW-1:0];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (start)
          state_nxt = (row_a != '0 && k != '0 &&
                       col_b != '0) ? LOAD : DONE;
      LOAD:
        if (cnt == CW'(k_q - 1'b1)) state_nxt = FLUSH;
      FLUSH:
        if (cnt == CW'(2*S-2)) state_nxt = WRITE;
      WRITE:
        if (cnt == CW'(S-1))
          state_nxt = last_tile ? DONE : LOAD;
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      t_q     <= '0;
      c_q     <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= (state_nxt != state) ? '0 : cnt + 1'b1;
      valid_q <= (state == LOAD);
      if (state == IDLE && start) begin
        m_q <= row_a;
        k_q <= k;
        n_q <= col_b;
        t_q <= '0;
        c_q <= '0;
      end
      if (state == WRITE && state_nxt == LOAD) begin
        if (c_q == nct - 1'b1) begin
          c_q <= '0;
          t_q <= t_q + 1'b1;
        end else begin
          c_q <= c_q + 1'b1;
        end
      end
    end
  end

  assign index_a = (state == LOAD) ?
    ADDR_W'(t_q) * ADDR_W'(k_q) + ADDR_W'(cnt) : '0;
  assign index_b = (state == LOAD) ?
    ADDR_W'(c_q) * ADDR_W'(k_q) + ADDR_W'(cnt) : '0;

  // Lanes past the matrix edge enter the array as zero
  logic signed [DATA_W-1:0] a_lane [S];
  logic signed [DATA_W-1:0] b_lane [S];
  logic signed [DATA_W-1:0] a_edge [S];
  logic signed [DATA_W-1:0] b_edge [S];

  always_comb begin
    for (int i = 0; i < S; i++) begin
      a_lane[i] = '0;
      b_lane[i] = '0;
      if (valid_q && int'(t_q) * S + i < int'(m_q))
        a_lane[i] = rd_data_a[i*DATA_W +: DATA_W];
      if (valid_q && int'(c_q) * S + i < int'(n_q))
        b_lane[i] = rd_data_b[i*DATA_W +: DATA_W];
    end
  end

  for (genvar i = 0; i < S; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_lane[i];
      assign b_edge[i] = b_lane[i];
    end else begin : g_delay
      logic signed [DATA_W-1:0] sa [i];
      logic signed [DATA_W-1:0] sb [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < i; d++) begin
            sa[d] <= '0;
            sb[d] <= '0;
          end
        end else begin
          sa[0] <= a_lane[i];
          sb[0] <= b_lane[i];
          for (int d = 1; d < i; d++) begin
            sa[d] <= sa[d-1];
            sb[d] <= sb[d-1];
          end
        end
      end
      assign a_edge[i] = sa[i-1];
      assign b_edge[i] = sb[i-1];
    end
  end

  logic signed [DATA_W-1:0] a_in  [S][S];
  logic signed [DATA_W-1:0] b_in  [S][S];
  logic signed [DATA_W-1:0] a_reg [S][S-1];
  logic signed [DATA_W-1:0] b_reg [S-1][S];
  logic signed [ACC_W-1:0]  acc   [S][S];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S-1; j++) begin
          a_reg[i][j] <= '0;
          b_reg[j][i] <= '0;
        end
    end else begin
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S-1; j++) begin
          a_reg[i][j] <= a_in[i][j];
          b_reg[j][i] <= b_in[j][i];
        end
    end
  end

  for (genvar i = 0; i < S; i++) begin : g_row
    for (genvar j = 0; j < S; j++) begin : g_pe
      if (j == 0) begin : g_al
        assign a_in[i][j] = a_edge[i];
      end else begin : g_ar
        assign a_in[i][j] = a_reg[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign b_in[i][j] = b_edge[j];
      end else begin : g_bd
        assign b_in[i][j] = b_reg[i-1][j];
      end

      logic signed [2*DATA_W-1:0] prod;
      logic signed [ACC_W-1:0]    p;
      assign prod = a_in[i][j] * b_in[i][j];
      assign p    = ACC_W'(prod);

`ifdef TPU_SAT_EN
      logic signed [ACC_W:0] sum;
      logic                  sat;
      assign sum = {acc[i][j][ACC_W-1], acc[i][j]} +
                   {p[ACC_W-1], p};
      // Sticky clamp: a saturated element ignores later terms
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc[i][j] <= '0;
          sat       <= 1'b0;
        end else if (clr) begin
          acc[i][j] <= '0;
          sat       <= 1'b0;
        end else if (!sat) begin
          if (sum[ACC_W] != sum[ACC_W-1]) begin
            sat       <= 1'b1;
            acc[i][j] <= sum[ACC_W] ?
              {1'b1, {(ACC_W-1){1'b0}}} :
              {1'b0, {(ACC_W-1){1'b1}}};
          end else begin
            acc[i][j] <= sum[ACC_W-1:0];
          end
        end
      end
`else
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      acc[i][j] <= '0;
        else if (clr) acc[i][j] <= '0;
        else          acc[i][j] <= acc[i][j] + p;
      end
`endif
    end
  end

  logic [S*ACC_W-1:0] row_word;

  always_comb begin
    row_word = '0;
    for (int j = 0; j < S; j++)
      if (int'(c_q) * S + j < int'(n_q))
        row_word[j*ACC_W +: ACC_W] = acc[rsel][j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_out   <= 1'b0;
      index_out   <= '0;
      wr_data_out <= '0;
    end else begin
      wr_en_out <= 1'b0;
      if (state == WRITE) begin
        wr_en_out   <= (int'(t_q) * S + int'(rsel))
                       < int'(m_q);
        index_out   <= (ADDR_W'(t_q) * ADDR_W'(nct) +
                        ADDR_W'(c_q)) * ADDR_W'(S) +
                       ADDR_W'(rsel);
        wr_data_out <= row_word;
      end
    end
  end

endmodule

// File: tb/tb_tpu_gemm_engine.sv
// tb_tpu_gemm_engine: random GEMM runs against an integer matrix model.
// Buffers are modelled as arrays with one-cycle read latency.
module tb_tpu_gemm_engine;
  localparam int S      = 4;
  localparam int DIM_W  = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [DIM_W-1:0] row_a = '0, k = '0, col_b = '0;
  logic busy, done, wr_en_out;
  logic [ADDR_W-1:0] index_a, index_b, index_out;
  logic [S*DATA_W-1:0] rd_data_a = '0, rd_data_b = '0;
  logic [S*ACC_W-1:0] wr_data_out;

  logic [S*DATA_W-1:0] mem_a [256];
  logic [S*DATA_W-1:0] mem_b [256];
  logic [S*ACC_W-1:0]  out_mem [int];
  int a_m [16][16];
  int b_m [16][16];

  int n_chk = 0, n_fail = 0;
  int done_cyc, done_cnt, busy_cnt, wr_cnt, rd_seen;

  tpu_gemm_engine #(
    .ARRAY_SIZE(S), .DIM_W(DIM_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .row_a(row_a), .k(k), .col_b(col_b),
    .busy(busy), .done(done),
    .index_a(index_a), .rd_data_a(rd_data_a),
    .index_b(index_b), .rd_data_b(rd_data_b),
    .wr_en_out(wr_en_out), .index_out(index_out),
    .wr_data_out(wr_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data_a <= mem_a[index_a[7:0]];
    rd_data_b <= mem_b[index_b[7:0]];
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] gold(int r, int c, int kk);
    int s;
    s = 0;
`ifdef TPU_SAT_EN
    begin
      bit sat;
      sat = 0;
      for (int q = 0; q < kk; q++)
        if (!sat) begin
          s += a_m[r][q] * b_m[q][c];
          if (s > 32767) begin s = 32767; sat = 1; end
          else if (s < -32768) begin s = -32768; sat = 1; end
        end
    end
`else
    for (int q = 0; q < kk; q++)
      s += a_m[r][q] * b_m[q][c];
`endif
    return 16'(s);
  endfunction

  // Build matrices and lay them out in buffer words; padding lanes get junk
  task automatic fill(input int m, input int kk, input int n,
                      input bit rnd, input int va, input int vb);
    logic [7:0] x;
    logic [S*DATA_W-1:0] w;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        x = 8'($urandom);
        a_m[r][c] = rnd ? int'($signed(x)) : va;
        x = 8'($urandom);
        b_m[r][c] = rnd ? int'($signed(x)) : vb;
      end
    for (int t = 0; t < (m + S - 1) / S; t++)
      for (int q = 0; q < kk; q++) begin
        for (int i = 0; i < S; i++)
          w[i*DATA_W +: DATA_W] = (t*S + i < m) ?
            8'(a_m[t*S+i][q]) : 8'($urandom);
        mem_a[t*kk + q] = w;
      end
    for (int c = 0; c < (n + S - 1) / S; c++)
      for (int q = 0; q < kk; q++) begin
        for (int j = 0; j < S; j++)
          w[j*DATA_W +: DATA_W] = (c*S + j < n) ?
            8'(b_m[q][c*S+j]) : 8'($urandom);
        mem_b[c*kk + q] = w;
      end
  endtask

  task automatic launch(input int m, input int kk, input int n);
    out_mem.delete();
    @(negedge clk);
    row_a = DIM_W'(m);
    k     = DIM_W'(kk);
    col_b = DIM_W'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    row_a = DIM_W'($urandom);
    k     = DIM_W'($urandom);
    col_b = DIM_W'($urandom);
  endtask

  task automatic monitor(input int budget, input int pulse_cyc);
    done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    wr_cnt = 0; rd_seen = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (index_a != '0 || index_b != '0) rd_seen++;
      if (wr_en_out) begin
        wr_cnt++;
        out_mem[int'(index_out)] = wr_data_out;
      end
      start = (n == pulse_cyc);
      if (n == pulse_cyc) begin
        row_a = 4'd1; k = 4'd9; col_b = 4'd2;
      end
    end
    start = 1'b0;
  endtask

  function automatic int exp_done(int m, int kk, int n);
    if (m == 0 || kk == 0 || n == 0) return 1;
    return ((m + S - 1) / S) * ((n + S - 1) / S) *
           (kk + 3*S - 1) + 1;
  endfunction

  task automatic verify(input int m, input int kk, input int n);
    int nrt, nct, idx, ed;
    logic [S*ACC_W-1:0] ew, gw;
    nrt = (m + S - 1) / S;
    nct = (n + S - 1) / S;
    ed  = exp_done(m, kk, n);
    check("done_cycle", 64'(done_cyc), 64'(ed));
    check("done_count", 64'(done_cnt), 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'(ed));
    check("write_count", 64'(wr_cnt), 64'(m * nct));
    for (int t = 0; t < nrt; t++)
      for (int c = 0; c < nct; c++)
        for (int r = 0; r < S; r++) begin
          idx = (t*nct + c)*S + r;
          if (t*S + r < m) begin
            for (int j = 0; j < S; j++)
              ew[j*ACC_W +: ACC_W] = (c*S + j < n) ?
                gold(t*S + r, c*S + j, kk) : 16'h0;
            gw = out_mem.exists(idx) ? out_mem[idx] : 'x;
            check("out_word", gw, ew);
          end else begin
            check("no_write_row", 64'(out_mem.exists(idx)), 64'd0);
          end
        end
  endtask

  task automatic run(input int m, input int kk, input int n,
                     input bit rnd, input int va, input int vb);
    fill(m, kk, n, rnd, va, vb);
    launch(m, kk, n);
    monitor(exp_done(m, kk, n) + 6, 0);
    verify(m, kk, n);
  endtask

  task automatic run_degen(input int m, input int kk, input int n);
    launch(m, kk, n);
    monitor(8, 0);
    check("degen_done_cycle", 64'(done_cyc), 64'd1);
    check("degen_busy", 64'(busy_cnt), 64'd1);
    check("degen_reads", 64'(rd_seen), 64'd0);
    check("degen_writes", 64'(wr_cnt), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_en", 64'(wr_en_out), 64'd0);
    check("rst_index_out", 64'(index_out), 64'd0);
    check("rst_wr_data", 64'(wr_data_out), 64'd0);
    rst = 1'b0;

    // all-ones A by all-twos B
    run(4, 4, 4, 1'b0, 1, 2);
    check("t1_idx0", 64'(out_mem.exists(0)), 64'd1);
    check("t1_idx3", 64'(out_mem.exists(3)), 64'd1);

    // edge tiles with random signed data
    run(5, 3, 6, 1'b1, 0, 0);

    run_degen(4, 0, 4);
    run_degen(0, 4, 4);
    run_degen(4, 4, 0);

    // reset in the middle of FLUSH
    fill(4, 4, 4, 1'b0, 1, 2);
    launch(4, 4, 4);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_wr_en", 64'(wr_en_out), 64'd0);
    check("mid_rst_index_a", 64'(index_a), 64'd0);
    check("mid_rst_index_b", 64'(index_b), 64'd0);
    check("mid_rst_index_out", 64'(index_out), 64'd0);
    check("mid_rst_wr_data", 64'(wr_data_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    monitor(25, 0);
    check("post_rst_writes", 64'(wr_cnt), 64'd0);
    check("post_rst_busy", 64'(busy_cnt), 64'd0);
    run(4, 4, 4, 1'b0, 1, 2);

    // second start while busy must be ignored
    fill(4, 4, 4, 1'b1, 0, 0);
    launch(4, 4, 4);
    monitor(exp_done(4, 4, 4) + 6, 5);
    verify(4, 4, 4);

    // long accumulation of max-positive operands
    run(4, 15, 4, 1'b0, 127, 127);
`ifdef TPU_SAT_EN
    check("big_lane", 64'(out_mem[0][15:0]), 64'h7FFF);
`else
    check("big_lane", 64'(out_mem[0][15:0]), 64'hB10F);
`endif

    for (int it = 0; it < 5; it++)
      run($urandom_range(1, 9), $urandom_range(1, 15),
          $urandom_range(1, 9), 1'b1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tpu_gemm_engine.md
Name: tpu_gemm_engine

Overview:
Parametrised output-stationary systolic GEMM engine, ARRAY_SIZE x ARRAY_SIZE PEs, with its own tile sequencer. Computes OUT = A x B for arbitrary row_a x k x col_b, tiling the output over the array.
- Reads packed operand words from the A and B global buffers.
- Writes packed accumulator rows to the output global buffer.
- Sits between the top-level start/done control and the three global buffers.

Parameters:
ARRAY_SIZE, 4, PEs per array side (S)
DIM_W, 4, width of the dimension inputs
ADDR_W, 16, buffer index width
DATA_W, 8, signed operand element width
ACC_W, 16, signed accumulator and output element width

Ports:
clk  in  1  clock, single domain
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE
row_a  in  DIM_W  rows of A (M)
k  in  DIM_W  shared dimension (K)
col_b  in  DIM_W  columns of B (N)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
index_a  out  ADDR_W  A buffer read index
rd_data_a  in  S*DATA_W  A buffer read word
index_b  out  ADDR_W  B buffer read index
rd_data_b  in  S*DATA_W  B buffer read word
wr_en_out  out  1  output buffer write strobe
index_out  out  ADDR_W  output buffer write index
wr_data_out  out  S*ACC_W  output buffer write word

Behaviour:
- Reset (async, any state, including mid-tile): state IDLE; busy, done, wr_en_out = 0; all indices, wr_data_out, counters and accumulators = 0. No write issues after rst rises.
- start in IDLE latches row_a, k and col_b. Inputs are ignored afterwards until return to IDLE. start while busy is ignored.
- Tile counts: NRT = ceil(M/S), NCT = ceil(N/S). Tile order is row-tile t outer, col-tile c inner.
- Memory layout:
  - A word at t*K+kk: lane i (bits i*DATA_W +: DATA_W) = A[t*S+i][kk].
  - B word at c*K+kk: lane j = B[kk][c*S+j].
  - Output word for tile row r at (t*NCT+c)*S+r: lane j = OUT[t*S+r][c*S+j].
- Buffer read latency is 1 cycle: rd_data is valid the cycle after the index is presented.
- States: IDLE, LOAD, FLUSH, WRITE, DONE.
- Transitions:
  - IDLE -> LOAD on start when M, K, N are all nonzero. Otherwise IDLE -> DONE.
  - LOAD: K cycles. Issues index kk=0..K-1. Accumulators clear on LOAD entry.
  - FLUSH: 2S-1 cycles. Covers read latency plus skew drain.
  - WRITE: S cycles, r = 0..S-1.
  - After WRITE: go to LOAD for the next tile, or to DONE after the last tile.
  - DONE: 1 cycle, done=1, then IDLE.
- Skew: A lane i is delayed i cycles, B lane j is delayed j cycles. Operands propagate one PE per cycle, right (A) and down (B).
- PE arithmetic: acc += sext(a*b). The product is signed 2*DATA_W, sign-extended or truncated to ACC_W, and the accumulation wraps two's complement.
- Edge tiles:
  - A/B lanes beyond M/N are forced to 0 at the array input.
  - In WRITE, wr_en_out = 0 for rows t*S+r >= M. The cycle is still spent.
  - Output lanes with c*S+j >= N are written as 0.
- Timing: start sampled at edge 0. done is high in cycle T*(K+3S-1)+1, where T = NRT*NCT. Degenerate dimensions give done in cycle 1 with no buffer accesses.
- wr_en_out, index_out and wr_data_out are registered and change together.

Optional Feature:
TPU_SAT_EN
- Defined: each accumulation saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Once saturated, an element stays clamped until the next LOAD clear.
- Undefined: accumulation wraps modulo 2^ACC_W.

Test Plan:
1. S=4, M=K=N=4, all A=1, B=2 -> four writes at index 0..3, every lane 8; done in cycle 16; busy cycles 1..16.
2. M=5, K=3, N=6 (4 tiles), random signed data -> done in cycle 57; tile (1,c) writes only r=0 (index 8, 12); c=1 lanes 2,3 = 0; values match golden model.
3. K=0 (M=N=4) -> done in cycle 1, no reads issued, wr_en_out never high; same for M=0 and for N=0.
4. rst pulsed during FLUSH of test 1 -> all outputs 0 immediately, no write follows; a subsequent start completes correctly in 16 cycles.
5. Second start pulsed in cycle 5 of test 1 -> ignored; exactly one done, dimensions unchanged.
6. M=K... M=N=4, K=15, A=B=127 -> without TPU_SAT_EN every lane = 0xB10F (-20209); with TPU_SAT_EN every lane = 0x7FFF.
